// File: rtl/time_counter.sv
// BCD hour/minute/second counter driven by three asynchronous count strobes.
// Each strobe is synchronised, rising-edge detected and advances one field.
module time_counter #(
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_s,
    input  logic       clk_m,
    input  logic       clk_h,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       s_bit,
    output logic       m_bit
);

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    // Terminal value is compared directly so the field never leaves 00..MOD-1.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    localparam logic [7:0] SEC_LAST  = to_bcd(SEC_MOD - 1);
    localparam logic [7:0] MIN_LAST  = to_bcd(MIN_MOD - 1);
    localparam logic [7:0] HOUR_LAST = to_bcd(HOUR_MOD - 1);

    // Bit order in the strobe vectors: [0]=seconds, [1]=minutes, [2]=hours.
    logic [2:0] raw;
    logic [2:0] strobe_s1;
    logic [2:0] strobe_s2;
    logic [2:0] strobe_d;
    logic [2:0] rise;

    assign raw  = {clk_h, clk_m, clk_s};
    assign rise = strobe_s2 & ~strobe_d;

    // Loading the raw level on reset makes a strobe held high across release look already-seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_s1 <= raw;
            strobe_s2 <= raw;
            strobe_d  <= raw;
        end else begin
            strobe_s1 <= raw;
            strobe_s2 <= strobe_s1;
            strobe_d  <= strobe_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec   <= 8'h00;
            min   <= 8'h00;
            hour  <= 8'h00;
            s_bit <= 1'b0;
            m_bit <= 1'b0;
        end else begin
            s_bit <= rise[0] && (sec == SEC_LAST);
            m_bit <= rise[1] && (min == MIN_LAST);
            if (rise[0])
                sec <= bcd_inc(sec, SEC_LAST);
            if (rise[1])
                min <= bcd_inc(min, MIN_LAST);
            if (rise[2])
                hour <= bcd_inc(hour, HOUR_LAST);
        end
    end

endmodule
